// File: rtl/systolic_skew_feeder.sv
// Skews K-step operand beats onto the array's left/top edges; lane i adds i+1 ce cycles of delay.
// Backpressure: s_ready only in STREAM, a missing beat there stalls the array (ce=0).
module systolic_skew_feeder #(
    parameter int N  = 4,
    parameter int AW = 8,
    parameter int BW = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            s_valid,
    output logic            s_ready,
    input  logic [N*AW-1:0] s_a,
    input  logic [N*BW-1:0] s_b,
    input  logic            s_last,
    output logic [N*AW-1:0] a_edge,
    output logic [N*BW-1:0] b_edge,
    output logic            ce,
    output logic            load_acc,
    output logic            done,
    output logic            busy
);
    localparam int CW = $clog2(2*N+2);
    localparam logic [CW-1:0] DRAIN_LOAD = CW'(2*N+1);

    typedef enum logic [2:0] {IDLE, CLEAR, STREAM, DRAIN, DONE} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          accept;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        s_ready   = 1'b0;
        ce        = 1'b0;
        load_acc  = 1'b0;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (s_valid) state_nxt = CLEAR;
            end
            CLEAR: begin
                ce        = 1'b1;
                load_acc  = 1'b1;
                state_nxt = STREAM;
            end
            STREAM: begin
                s_ready = 1'b1;
                ce      = s_valid;
                accept  = s_valid;
                if (s_valid && s_last) begin
                    cnt_nxt   = DRAIN_LOAD;
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                ce = 1'b1;
                if (cnt == '0) state_nxt = DONE;
                else           cnt_nxt   = cnt - 1'b1;
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            done  <= 1'b0;
            busy  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            done  <= (state_nxt == DONE);
            busy  <= (state_nxt != IDLE);
        end
    end

    // Heads inject zeros on non-accept ce cycles so the array drains clean.
    for (genvar i = 0; i < N; i++) begin : g_lane
        logic [AW-1:0] a_sr [0:i];
        logic [BW-1:0] b_sr [0:i];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int k = 0; k <= i; k++) begin
                    a_sr[k] <= '0;
                    b_sr[k] <= '0;
                end
            end else if (ce) begin
                a_sr[0] <= accept ? s_a[i*AW +: AW] : '0;
                b_sr[0] <= accept ? s_b[i*BW +: BW] : '0;
                for (int k = 1; k <= i; k++) begin
                    a_sr[k] <= a_sr[k-1];
                    b_sr[k] <= b_sr[k-1];
                end
            end
        end

        assign a_edge[i*AW +: AW] = a_sr[i];
        assign b_edge[i*BW +: BW] = b_sr[i];
    end

endmodule
